stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DIV, default 500000, SHALL set the 50 MHz clock cycles per 1/100 s tick (legal range 2..2^20).
REQ-002 Port CLK  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 Port RST  input  1  SHALL be the synchronous, active-low reset: 0 sampled at a CLK rising edge resets the block.
REQ-004 Port BIN  input  3  SHALL carry debounced one-cycle button pulses from the upstream debouncer: [0] start/stop, [1] clear, [2] lap.
REQ-005 Port DOUT  output  16  SHALL present four BCD digits {sec tens, sec ones, tenths, hundredths}, [15:12] most significant.
REQ-006 Port RUN  output  1  SHALL be 1 while the state is RUN or LAP.
REQ-007 Port HOLD  output  1  SHALL be 1 while the state is LAP.
REQ-008 Port WRAP  output  1  SHALL pulse high for one cycle when the count wraps from 59.99 to 00.00.

Function
REQ-009 States SHALL be IDLE, RUN, PAUSE, LAP; all outputs registered.
REQ-010 The block SHALL act on at most one button per cycle, priority BIN[1] > BIN[0] > BIN[2]; lower-priority pulses in the same cycle are discarded.
REQ-011 Transitions: IDLE+BIN[0] -> RUN; RUN+BIN[0] -> PAUSE; PAUSE+BIN[0] -> RUN; LAP+BIN[0] -> PAUSE; RUN+BIN[2] -> LAP; LAP+BIN[2] -> RUN.
REQ-012 BIN[1] in IDLE or PAUSE SHALL clear count, prescaler and DOUT to 0 and enter IDLE; in RUN or LAP it SHALL be ignored.
REQ-013 A pulse arriving in cycle n SHALL be reflected in RUN/HOLD at cycle n+1.
REQ-014 Prescaler SHALL count 0..DIV-1 only in RUN and LAP, hold its value in PAUSE (resume keeps partial interval), and be 0 in IDLE; tick asserts when prescaler equals DIV-1.
REQ-015 Each tick SHALL increment the BCD count with carries: hundredths 9->0, tenths 9->0, sec ones 9->0, sec tens 5->0.
REQ-016 Count 59.99 plus tick SHALL become 00.00 and assert WRAP in the cycle the new count is registered; counting continues.
REQ-017 In RUN, IDLE and PAUSE, DOUT SHALL equal the internal count, updated one cycle after the tick.
REQ-018 In LAP, DOUT SHALL hold the count captured on entry while the internal count keeps advancing; on LAP->RUN or LAP->PAUSE DOUT SHALL show the live count from the next cycle.
REQ-019 A tick coinciding with BIN[0] in RUN SHALL be applied before pausing (count includes that tick).
REQ-020 BIN values outside a valid transition SHALL have no effect.

Reset
REQ-021 RST=0 SHALL set state IDLE, prescaler 0, count 0, DOUT 16'h0000, RUN 0, HOLD 0, WRAP 0, overriding any simultaneous BIN or tick.
REQ-022 Reset asserted mid-count or in LAP SHALL discard all held values; the first BIN[0] after release starts from 00.00.

Configuration
REQ-023 Macro STOPWATCH_LAP_EN defined SHALL compile in the LAP state, HOLD behaviour and BIN[2] handling.
REQ-024 With STOPWATCH_LAP_EN undefined, BIN[2] SHALL be ignored, LAP SHALL not exist, HOLD SHALL be tied 0 and DOUT SHALL always track the count.

Verification (DIV=4)
REQ-025 Reset, then BIN=3'b001 one cycle -> RUN=1 next cycle; after 40 cycles DOUT=16'h0010.
REQ-026 Running, BIN[0] pulse, wait 100 cycles, BIN[0] pulse -> DOUT frozen during pause; prescaler resumes from held value, no lost or extra tick.
REQ-027 Preload to 59.98 by running 5998 ticks, run 2 more ticks -> DOUT 16'h5999 then 16'h0000 with WRAP high exactly one cycle.
REQ-028 Lap enabled: running at 00.05, BIN[2] -> HOLD=1, DOUT stays 16'h0005 for 20 cycles; BIN[2] -> DOUT=16'h0010.
REQ-029 BIN=3'b111 in PAUSE -> clear wins: IDLE, DOUT=0; BIN=3'b011 in RUN -> clear ignored, BIN[0] acts: PAUSE.
REQ-030 RST=0 for one cycle during LAP -> next cycle all outputs 0, state IDLE, count 00.00.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: a BCD stopwatch (00.00 .. 59.99) with start/stop, clear and an optional lap hold.
// A prescaler divides CLK down to 1/100 s ticks. Every output is registered.
// Optional feature: define STOPWATCH_LAP_EN to compile in the LAP state, HOLD and BIN[2] handling.
module stopwatch_ctrl #(
  parameter int unsigned DIV = 500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  BIN,
  output logic [15:0] DOUT,
  output logic        RUN,
  output logic        HOLD,
  output logic        WRAP
);

  localparam logic [19:0] PreMax = 20'(DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
`ifdef STOPWATCH_LAP_EN
    , StLap = 2'd3
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] pre_q, pre_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dout_q, dout_d;
  logic        run_q, run_d;
  logic        hold_q, hold_d;
  logic        wrap_q, wrap_d;
  logic        lap_q, lap_d;
  logic        counting, tick, clr;

`ifdef STOPWATCH_LAP_EN
  assign lap_q = (state_q == StLap);
  assign lap_d = (state_d == StLap);
`else
  assign lap_q = 1'b0;
  assign lap_d = 1'b0;
  // The lap button has no function in this build.
  logic unused_lap;
  assign unused_lap = BIN[2];
`endif

  // Next state, prescaler and BCD count; the tick is applied before any button action.
  always_comb begin
    state_d  = state_q;
    pre_d    = pre_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    counting = (state_q == StRun) || lap_q;
    tick     = counting && (pre_q == PreMax);
    clr      = BIN[1] && ((state_q == StIdle) || (state_q == StPause));

    if (counting) begin
      pre_d = tick ? '0 : pre_q + 20'd1;
    end

    if (tick) begin
      if (cnt_q[3:0] != 4'd9) begin
        cnt_d[3:0] = cnt_q[3:0] + 4'd1;
      end else begin
        cnt_d[3:0] = 4'd0;
        if (cnt_q[7:4] != 4'd9) begin
          cnt_d[7:4] = cnt_q[7:4] + 4'd1;
        end else begin
          cnt_d[7:4] = 4'd0;
          if (cnt_q[11:8] != 4'd9) begin
            cnt_d[11:8] = cnt_q[11:8] + 4'd1;
          end else begin
            cnt_d[11:8] = 4'd0;
            if (cnt_q[15:12] != 4'd5) begin
              cnt_d[15:12] = cnt_q[15:12] + 4'd1;
            end else begin
              cnt_d[15:12] = 4'd0;
              wrap_d       = 1'b1;
            end
          end
        end
      end
    end

    // Clear only counts as a button where it is legal, so an ignored clear lets BIN[0]/BIN[2] act.
    if (clr) begin
      state_d = StIdle;
      pre_d   = '0;
      cnt_d   = '0;
    end else if (BIN[0]) begin
      unique case (state_q)
        StIdle:  state_d = StRun;
        StRun:   state_d = StPause;
        StPause: state_d = StRun;
`ifdef STOPWATCH_LAP_EN
        StLap:   state_d = StPause;
`endif
        default: state_d = state_q;
      endcase
    end
`ifdef STOPWATCH_LAP_EN
    else if (BIN[2]) begin
      if (state_q == StRun) begin
        state_d = StLap;
      end else if (state_q == StLap) begin
        state_d = StRun;
      end
    end
`endif
  end

  // Registered outputs; the display freezes only while staying in LAP.
  always_comb begin
    run_d  = (state_d == StRun) || lap_d;
    hold_d = lap_d;
    dout_d = (lap_d && lap_q) ? dout_q : cnt_d;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= StIdle;
      pre_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      run_q   <= 1'b0;
      hold_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      run_q   <= run_d;
      hold_q  <= hold_d;
      wrap_q  <= wrap_d;
    end
  end

  assign DOUT = dout_q;
  assign RUN  = run_q;
  assign HOLD = hold_q;
  assign WRAP = wrap_q;

endmodule
